interrupt_request_priority: RTL and testbench
=============================================

// Module: interrupt_request_priority
// PURPOSE
//  Upstream neighbour of the in-service register stage in the 8259A-style controller.
//  Synchronises the eight IR pins and holds them in the interrupt request register
//  (IRR) with edge or level sensing. Applies the OCW1 mask and rotating priority.
//  Produces a registered one-hot highest_priority_interrupt for the ISR stage and
//  an interrupt_pending flag that control logic turns into INT.
// PARAMETERS
//  SYNC_STAGES  2  flops per IR pin synchroniser (>=2)
// PORTS
//  clk                         in   1  system clock, all state on rising edge
//  rst_n                       in   1  asynchronous active-low reset
//  interrupt_request_pin       in   8  raw IR0..IR7 pins, asynchronous
//  level_or_edge_triggered     in   1  ICW1 LTIM: 1=level, 0=rising edge
//  interrupt_mask              in   8  OCW1 mask, 1=masked
//  special_mask_mode           in   1  OCW3 SMM, 1=special mask mode
//  in_service_register         in   8  current ISR from ISR stage
//  freeze                      in   1  high during INTA sequence; holds resolver output
//  clear_interrupt_request     in   8  one-hot, clears IRR bit at acknowledge
//  priority_rotate             in   1  single-cycle pulse: load new lowest level
//  priority_rotate_level       in   3  level that becomes lowest priority
//  icw1_write                  in   1  single-cycle pulse: initialisation command
//  interrupt_request_register  out  8  IRR contents (readable via OCW3)
//  highest_priority_interrupt  out  8  one-hot granted request to ISR stage, or 0
//  interrupt_pending           out  1  |highest_priority_interrupt
//  lowest_priority_level       out  3  current lowest-priority level
// BEHAVIOUR
//  Reset: sync chains, edge-history, IRR, highest_priority_interrupt and
//   interrupt_pending = 0. lowest_priority_level = 3'd7, so IR0 is highest.
//  Sync: each pin passes through SYNC_STAGES flops; s = last stage.
//   prev = s delayed one clk.
//  IRR update per bit i (priority: icw1_write > clear > set > hold):
//   - Edge mode: set on s&~prev. Cleared if s==0 (request withdrawn).
//   - Level mode: IRR[i] <= s[i].
//   - clear_interrupt_request[i]=1 forces IRR[i]=0 that cycle, even if a set
//     coincides. In level mode, a still-high pin resets the bit next cycle.
//   - IRR is not affected by freeze.
//  Resolve (combinational from registered IRR, mask, ISR, lowest level):
//   - Priority order starts at (lowest_priority_level+1) mod 8 and wraps through
//     lowest_priority_level.
//   - SMM=0: cand = IRR & ~mask. Take highest-priority cand bit. Grant it only if
//     it is strictly higher than the highest-priority ISR bit (ISR=0 always grants).
//   - SMM=1: cand = IRR & ~mask & ~ISR. Take highest-priority cand bit; no ISR
//     comparison.
//   - No cand, or blocked: result 8'h00.
//  Output: highest_priority_interrupt <= result when freeze=0; holds when freeze=1.
//   Latency: IRR change -> output = 1 clk. Pin edge -> IRR = SYNC_STAGES+1 clks.
//   interrupt_pending is registered with the same enable.
//  Rotation: priority_rotate loads lowest_priority_level <= priority_rotate_level.
//   The new order applies to the next resolve.
//  icw1_write (wins over priority_rotate and every IRR event):
//   - IRR <= 0, highest_priority_interrupt <= 0, lowest_priority_level <= 7.
//   - prev <= s, so a pin already high needs a fresh low->high edge in edge mode.
//  rst_n low mid-operation clears everything immediately (asynchronous).
//   The first edge is recognised only after rst_n release plus full sync latency.
// TESTING
//  - Edge mode, IR3 0->1 -> IRR=8'h08 after 3 clks; hpi=8'h08 and pending=1 at clk 4.
//    IR3 falls before ack -> IRR=0, hpi=0.
//  - IR1 and IR5 rise together, mask=0, ISR=0 -> hpi=8'h02.
//    Then rotate with level=1 -> hpi=8'h20 next clk.
//  - SMM=0, ISR=8'h04: IR4 request -> hpi=0. Add IR0 -> hpi=8'h01.
//    SMM=1, mask=8'h04, ISR=8'h04, IR6 -> hpi=8'h40.
//  - freeze=1 with hpi=8'h02, IR0 rises -> hpi stays 8'h02 (IRR=8'h03).
//    Drop freeze -> hpi=8'h01 one clk later.
//  - Clear with IRR[1] set-edge same cycle -> IRR[1]=0 (clear wins).
//    Level mode, pin held high -> IRR[1]=1 next clk.
//  - Edge mode, IR2 high then icw1_write -> IRR=0, lowest=7, no re-set until IR2
//    goes 0->1. rst_n pulse mid-traffic -> all outputs 0, lowest=7.

Source files
------------

// File: rtl/interrupt_request_priority_if.sv
// Request/priority bus between control logic (master) and the IRR/priority resolver (slave).
interface interrupt_request_priority_if;
  logic [7:0] interrupt_request_pin;
  logic       level_or_edge_triggered;
  logic [7:0] interrupt_mask;
  logic       special_mask_mode;
  logic [7:0] in_service_register;
  logic       freeze;
  logic [7:0] clear_interrupt_request;
  logic       priority_rotate;
  logic [2:0] priority_rotate_level;
  logic       icw1_write;
  logic [7:0] interrupt_request_register;
  logic [7:0] highest_priority_interrupt;
  logic       interrupt_pending;
  logic [2:0] lowest_priority_level;

  modport master (
    output interrupt_request_pin, level_or_edge_triggered, interrupt_mask,
           special_mask_mode, in_service_register, freeze, clear_interrupt_request,
           priority_rotate, priority_rotate_level, icw1_write,
    input  interrupt_request_register, highest_priority_interrupt,
           interrupt_pending, lowest_priority_level
  );

  modport slave (
    input  interrupt_request_pin, level_or_edge_triggered, interrupt_mask,
           special_mask_mode, in_service_register, freeze, clear_interrupt_request,
           priority_rotate, priority_rotate_level, icw1_write,
    output interrupt_request_register, highest_priority_interrupt,
           interrupt_pending, lowest_priority_level
  );
endinterface

// File: rtl/interrupt_request_priority.sv
// IR pin synchroniser, interrupt request register and rotating priority resolver.
// Pin edge -> IRR in SYNC_STAGES+1 clks; IRR -> granted one-hot in 1 clk (held while frozen).
module interrupt_request_priority #(
  parameter int SYNC_STAGES = 2
) (
  input logic                          clk,
  input logic                          rst_n,
  interrupt_request_priority_if.slave  bus
);

  logic [SYNC_STAGES-1:0][7:0] sync;
  logic [7:0] s;
  logic [7:0] prev;
  logic [7:0] irr;
  logic [7:0] irr_next;
  logic [7:0] hpi;
  logic       pending;
  logic [2:0] lowest;

  assign s = sync[SYNC_STAGES-1];

  always_comb begin
    irr_next = irr;
    for (int i = 0; i < 8; i++) begin
      if (bus.icw1_write || bus.clear_interrupt_request[i])
        irr_next[i] = 1'b0;
      else if (bus.level_or_edge_triggered)
        irr_next[i] = s[i];
      else if (s[i] && !prev[i])
        irr_next[i] = 1'b1;
      else if (!s[i])
        irr_next[i] = 1'b0;
    end
  end

  // Walk levels from highest (lowest+1) to lowest, recording the first hit and its rank.
  logic [7:0] cand;
  logic [7:0] result;
  logic [2:0] start;
  logic [2:0] idx;
  logic [2:0] cand_idx;
  logic [2:0] cand_rank;
  logic [2:0] isr_rank;
  logic       cand_found;
  logic       isr_found;

  always_comb begin
    start      = lowest + 3'd1;
    cand       = irr & ~bus.interrupt_mask;
    if (bus.special_mask_mode)
      cand = cand & ~bus.in_service_register;
    idx        = 3'd0;
    cand_idx   = 3'd0;
    cand_rank  = 3'd0;
    isr_rank   = 3'd0;
    cand_found = 1'b0;
    isr_found  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!cand_found && cand[idx]) begin
        cand_found = 1'b1;
        cand_idx   = idx;
        cand_rank  = 3'(k);
      end
      if (!isr_found && bus.in_service_register[idx]) begin
        isr_found = 1'b1;
        isr_rank  = 3'(k);
      end
    end
    result = 8'h00;
    if (cand_found && (bus.special_mask_mode || !isr_found || cand_rank < isr_rank))
      result[cand_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      prev    <= 8'h00;
      irr     <= 8'h00;
      hpi     <= 8'h00;
      pending <= 1'b0;
      lowest  <= 3'd7;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.interrupt_request_pin};
      prev <= s;
      irr  <= irr_next;
      if (bus.icw1_write) begin
        hpi     <= 8'h00;
        pending <= 1'b0;
        lowest  <= 3'd7;
      end else begin
        if (!bus.freeze) begin
          hpi     <= result;
          pending <= |result;
        end
        if (bus.priority_rotate)
          lowest <= bus.priority_rotate_level;
      end
    end
  end

  assign bus.interrupt_request_register = irr;
  assign bus.highest_priority_interrupt = hpi;
  assign bus.interrupt_pending          = pending;
  assign bus.lowest_priority_level      = lowest;

endmodule

// File: tb/tb_interrupt_request_priority.sv
// Directed bench for interrupt_request_priority with hand-computed expectations.
module tb_interrupt_request_priority;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  interrupt_request_priority_if bus ();

  interrupt_request_priority #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.interrupt_request_pin   = 8'h00;
    bus.level_or_edge_triggered = 1'b0;
    bus.interrupt_mask          = 8'h00;
    bus.special_mask_mode       = 1'b0;
    bus.in_service_register     = 8'h00;
    bus.freeze                  = 1'b0;
    bus.clear_interrupt_request = 8'h00;
    bus.priority_rotate         = 1'b0;
    bus.priority_rotate_level   = 3'd0;
    bus.icw1_write              = 1'b0;
    #12;
    check_val("rst_irr", bus.interrupt_request_register, 8'h00);
    check_val("rst_hpi", bus.highest_priority_interrupt, 8'h00);
    check_val("rst_pend", 8'(bus.interrupt_pending), 8'h00);
    check_val("rst_low", 8'(bus.lowest_priority_level), 8'h07);
    rst_n = 1'b1;
    step(2);

    // Edge mode, IR3 rise then withdraw
    bus.interrupt_request_pin = 8'h08;
    step(2);
    check_val("ir3_irr_early", bus.interrupt_request_register, 8'h00);
    step(1);
    check_val("ir3_irr", bus.interrupt_request_register, 8'h08);
    check_val("ir3_hpi_early", bus.highest_priority_interrupt, 8'h00);
    step(1);
    check_val("ir3_hpi", bus.highest_priority_interrupt, 8'h08);
    check_val("ir3_pend", 8'(bus.interrupt_pending), 8'h01);
    bus.interrupt_request_pin = 8'h00;
    step(3);
    check_val("ir3_drop_irr", bus.interrupt_request_register, 8'h00);
    step(1);
    check_val("ir3_drop_hpi", bus.highest_priority_interrupt, 8'h00);
    check_val("ir3_drop_pend", 8'(bus.interrupt_pending), 8'h00);

    // IR1+IR5 with default and rotated priority
    bus.interrupt_request_pin = 8'h22;
    step(4);
    check_val("ir15_hpi", bus.highest_priority_interrupt, 8'h02);
    bus.priority_rotate       = 1'b1;
    bus.priority_rotate_level = 3'd1;
    step(1);
    bus.priority_rotate = 1'b0;
    check_val("rot_low", 8'(bus.lowest_priority_level), 8'h01);
    step(1);
    check_val("rot_hpi", bus.highest_priority_interrupt, 8'h20);

    // icw1 with pins still high: no re-set until a fresh edge
    bus.icw1_write = 1'b1;
    step(1);
    bus.icw1_write = 1'b0;
    check_val("icw1_irr", bus.interrupt_request_register, 8'h00);
    check_val("icw1_hpi", bus.highest_priority_interrupt, 8'h00);
    check_val("icw1_low", 8'(bus.lowest_priority_level), 8'h07);
    step(5);
    check_val("icw1_noreset", bus.interrupt_request_register, 8'h00);
    bus.interrupt_request_pin = 8'h00;
    step(3);
    bus.interrupt_request_pin = 8'h22;
    step(3);
    check_val("icw1_fresh_edge", bus.interrupt_request_register, 8'h22);
    bus.interrupt_request_pin = 8'h00;
    step(4);
    check_val("idle_irr", bus.interrupt_request_register, 8'h00);

    // ISR blocking, then special mask mode
    bus.in_service_register   = 8'h04;
    bus.interrupt_request_pin = 8'h10;
    step(4);
    check_val("isr_irr", bus.interrupt_request_register, 8'h10);
    check_val("isr_block", bus.highest_priority_interrupt, 8'h00);
    bus.interrupt_request_pin = 8'h11;
    step(4);
    check_val("isr_ir0", bus.highest_priority_interrupt, 8'h01);
    bus.special_mask_mode     = 1'b1;
    bus.interrupt_mask        = 8'h04;
    bus.interrupt_request_pin = 8'h40;
    step(6);
    check_val("smm_irr", bus.interrupt_request_register, 8'h40);
    check_val("smm_hpi", bus.highest_priority_interrupt, 8'h40);
    bus.special_mask_mode = 1'b0;
    step(1);
    step(1);
    check_val("nosmm_block", bus.highest_priority_interrupt, 8'h00);
    bus.interrupt_mask        = 8'h00;
    bus.in_service_register   = 8'h00;
    bus.interrupt_request_pin = 8'h00;
    step(5);

    // Freeze holds the grant while IRR keeps updating
    bus.interrupt_request_pin = 8'h02;
    step(4);
    check_val("frz_pre", bus.highest_priority_interrupt, 8'h02);
    bus.freeze                = 1'b1;
    bus.interrupt_request_pin = 8'h03;
    step(4);
    check_val("frz_irr", bus.interrupt_request_register, 8'h03);
    check_val("frz_hold", bus.highest_priority_interrupt, 8'h02);
    bus.freeze = 1'b0;
    step(1);
    check_val("frz_release", bus.highest_priority_interrupt, 8'h01);
    bus.interrupt_request_pin = 8'h00;
    step(5);

    // Clear coinciding with the set edge
    bus.interrupt_request_pin = 8'h02;
    step(2);
    bus.clear_interrupt_request = 8'h02;
    step(1);
    bus.clear_interrupt_request = 8'h00;
    check_val("clr_wins", bus.interrupt_request_register, 8'h00);
    step(2);
    check_val("clr_edge_stays", bus.interrupt_request_register, 8'h00);
    bus.level_or_edge_triggered = 1'b1;
    step(1);
    check_val("lvl_reset", bus.interrupt_request_register, 8'h02);
    bus.clear_interrupt_request = 8'h02;
    step(1);
    bus.clear_interrupt_request = 8'h00;
    check_val("lvl_clr", bus.interrupt_request_register, 8'h00);
    step(1);
    check_val("lvl_reassert", bus.interrupt_request_register, 8'h02);

    // Asynchronous reset mid-traffic
    bus.priority_rotate       = 1'b1;
    bus.priority_rotate_level = 3'd3;
    step(1);
    bus.priority_rotate = 1'b0;
    check_val("pre_rst_low", 8'(bus.lowest_priority_level), 8'h03);
    check_val("pre_rst_hpi", bus.highest_priority_interrupt, 8'h02);
    rst_n = 1'b0;
    #2;
    check_val("arst_irr", bus.interrupt_request_register, 8'h00);
    check_val("arst_hpi", bus.highest_priority_interrupt, 8'h00);
    check_val("arst_pend", 8'(bus.interrupt_pending), 8'h00);
    check_val("arst_low", 8'(bus.lowest_priority_level), 8'h07);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    check_val("post_rst_sync", bus.interrupt_request_register, 8'h00);
    step(1);
    check_val("post_rst_irr", bus.interrupt_request_register, 8'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
